// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
// XLEN mirrors the pipeline-wide address/data width.
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
  typedef enum logic [1:0] {NONE, INSTR, DATA} arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant/response bus used on both requester sides and on the memory side.
// The requester drives through master; the responder (arbiter or memory) uses slave.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
();

  logic            req;
  logic            we;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Fetch starvation guard: counts consecutive data wins while fetch waits and forces
// a fetch win once STARVE_LIMIT is reached. Used only with MEM_ARB_STARVE_GUARD_EN.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_pt,
  input  logic i_req,
  input  logic d_win,
  input  logic i_win,
  output logic force_fetch
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_pt) begin
      if (i_win || !i_req) begin
        starve_cnt_d = '0;
      end else if (d_win && (starve_cnt_q < Limit)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_fetch = i_req && (starve_cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time, data first.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long fetch can be starved by data traffic.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  instr,
  mem_arbiter_if.slave  data,
  mem_arbiter_if.master mem
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [BE_W-1:0] m_be_q, m_be_d;
  logic [XLEN-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0] m_wdata_q, m_wdata_d;

  logic arb_pt, d_win, i_win, force_fetch;

  // Arbitration happens in IDLE or on the response cycle, enabling back-to-back issue.
  assign arb_pt = (state_q == IDLE) || ((state_q == RESP) && mem.rvalid);
  assign d_win  = arb_pt && data.req && !force_fetch;
  assign i_win  = arb_pt && instr.req && !d_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .arb_pt     (arb_pt),
    .i_req      (instr.req),
    .d_win      (d_win),
    .i_win      (i_win),
    .force_fetch(force_fetch)
  );
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (d_win) begin
          state_d   = REQ;
          owner_d   = DATA;
          m_req_d   = 1'b1;
          m_we_d    = data.we;
          m_be_d    = data.be;
          m_addr_d  = data.addr;
          m_wdata_d = data.wdata;
        end else if (i_win) begin
          state_d   = REQ;
          owner_d   = INSTR;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = instr.addr;
          m_wdata_d = '0;
        end else if (state_q == RESP && mem.rvalid) begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      REQ: begin
        if (mem.gnt) begin
          state_d = RESP;
          m_req_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= NONE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign mem.req   = m_req_q;
  assign mem.we    = m_we_q;
  assign mem.be    = m_be_q;
  assign mem.addr  = m_addr_q;
  assign mem.wdata = m_wdata_q;

  assign instr.gnt    = (state_q == REQ) && mem.gnt && (owner_q == INSTR);
  assign data.gnt     = (state_q == REQ) && mem.gnt && (owner_q == DATA);
  assign instr.rvalid = (state_q == RESP) && mem.rvalid && (owner_q == INSTR);
  assign data.rvalid  = (state_q == RESP) && mem.rvalid && (owner_q == DATA);
  assign instr.rdata  = mem.rdata;
  assign data.rdata   = mem.rdata;

  // Fetch side never writes; its write-side fields are don't-care.
  logic unused_fetch_fields;
  assign unused_fetch_fields = ^{instr.we, instr.be, instr.wdata};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, memory model and response scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if instr_bus ();
  mem_arbiter_if data_bus ();
  mem_arbiter_if mem_bus ();

  mem_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .instr  (instr_bus),
    .data   (data_bus),
    .mem    (mem_bus)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    bit          chk_rdata;
  } txn_t;

  typedef struct {
    arb_owner_e  own;
    logic [31:0] rdata;
    bit          chk;
  } rsp_t;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned gd;
    int unsigned rd;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    bit          chk_rdata;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  txn_t        i_stim_q[$];
  txn_t        d_stim_q[$];
  rsp_t        rsp_q[$];
  arb_owner_e  ord_q[$];
  txn_t        i_cur, d_cur;
  bit          i_req_drv = 0, d_req_drv = 0;
  int unsigned gnt_dly = 0, rsp_dly = 0;
  bit          spur_req = 0;
  bit          d_gnt_seen = 0;
  logic [31:0] mem_arr [logic [31:0]];

  // Memory model state
  bit          phase = 0;
  int unsigned gcnt = 0, rcnt = 0, cyc = 0;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic        gnt_line, rv_line;
  logic [31:0] rdata_line;

  // Monitor history
  bit          prev_wait = 0, prev_gnt = 0, chk_mreq = 0, rv_seen = 0;
  logic        exp_mreq;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  logic [3:0]  prev_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, required 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : ~a;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = mem_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = d[b*8 +: 8];
    mem_arr[a] = v;
  endtask

  task automatic push_txn(input bit is_d, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_rdata, input bit chk);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    t.exp_we = exp_we; t.exp_be = exp_be; t.exp_rdata = exp_rdata; t.chk_rdata = chk;
    if (is_d) d_stim_q.push_back(t);
    else i_stim_q.push_back(t);
  endtask

  task automatic flush_tb();
    i_stim_q.delete(); d_stim_q.delete(); rsp_q.delete(); ord_q.delete();
    i_req_drv = 0; d_req_drv = 0;
    instr_bus.req = 1'b0; data_bus.req = 1'b0;
    prev_wait = 0; prev_gnt = 0; chk_mreq = 0; rv_seen = 0;
  endtask

  task automatic monitor();
    arb_owner_e eg, er;
    txn_t t;
    rsp_t r;
    if (chk_mreq) check("m_req after response", mem_bus.req, exp_mreq);
    chk_mreq = 0;
    if (prev_gnt) check("m_req drops after gnt", mem_bus.req, 1'b0);
    if (prev_wait && mem_bus.req) begin
      check("m_addr stable", mem_bus.addr, prev_addr);
      check("m_we stable", mem_bus.we, prev_we);
      check("m_be stable", mem_bus.be, prev_be);
      check("m_wdata stable", mem_bus.wdata, prev_wdata);
    end
    eg = NONE;
    if (gnt_line && mem_bus.req && ord_q.size() > 0) eg = ord_q.pop_front();
    check("i_gnt", instr_bus.gnt, eg == INSTR);
    check("d_gnt", data_bus.gnt, eg == DATA);
    if (eg != NONE) begin
      t = (eg == INSTR) ? i_cur : d_cur;
      check("m_addr at gnt", mem_bus.addr, t.addr);
      check("m_we at gnt", mem_bus.we, t.exp_we);
      check("m_be at gnt", mem_bus.be, t.exp_be);
      if (t.exp_we) check("m_wdata at gnt", mem_bus.wdata, t.wdata);
      r.own = eg; r.rdata = t.exp_rdata; r.chk = t.chk_rdata;
      rsp_q.push_back(r);
      if (eg == DATA) d_gnt_seen = 1;
    end
    er = NONE;
    if (rv_line && rsp_q.size() > 0) begin
      r = rsp_q.pop_front();
      er = r.own;
    end
    check("i_rvalid", instr_bus.rvalid, er == INSTR);
    check("d_rvalid", data_bus.rvalid, er == DATA);
    if (er == INSTR && r.chk) check("i_rdata", instr_bus.rdata, r.rdata);
    if (er == DATA && r.chk) check("d_rdata", data_bus.rdata, r.rdata);
    rv_seen = (er != NONE);
    prev_gnt = (eg != NONE);
    prev_wait = mem_bus.req && !gnt_line;
    prev_addr = mem_bus.addr; prev_we = mem_bus.we;
    prev_be = mem_bus.be; prev_wdata = mem_bus.wdata;
  endtask

  task automatic requesters();
    if (instr_bus.gnt === 1'b1) i_req_drv = 0;
    if (data_bus.gnt === 1'b1) d_req_drv = 0;
    if (!i_req_drv && i_stim_q.size() > 0) begin i_cur = i_stim_q.pop_front(); i_req_drv = 1; end
    if (!d_req_drv && d_stim_q.size() > 0) begin d_cur = d_stim_q.pop_front(); d_req_drv = 1; end
    instr_bus.req = i_req_drv; instr_bus.addr = i_cur.addr;
    instr_bus.we = 1'b1; instr_bus.be = 4'h0; instr_bus.wdata = 32'hFFFF_FFFF;
    data_bus.req = d_req_drv; data_bus.we = d_cur.we; data_bus.be = d_cur.be;
    data_bus.addr = d_cur.addr; data_bus.wdata = d_cur.wdata;
  endtask

  // Memory responder plus per-cycle monitor, all on the falling edge.
  initial begin
    mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    i_cur = '{default: '0}; d_cur = '{default: '0};
    requesters();
    forever begin
      @(negedge clk);
      cyc++;
      gnt_line = 1'b0; rv_line = 1'b0; rdata_line = 32'hC0DE_0000 ^ cyc;
      if (phase) begin
        if (rcnt == rsp_dly) begin
          rv_line = 1'b1; phase = 0;
          if (lat_we) mem_write(lat_addr, lat_be, lat_wdata);
          else rdata_line = mem_read(lat_addr);
        end else rcnt++;
      end else if (mem_bus.req === 1'b1) begin
        if (gcnt == gnt_dly) begin
          gnt_line = 1'b1; phase = 1; rcnt = 0; gcnt = 0;
          lat_addr = mem_bus.addr; lat_we = mem_bus.we;
          lat_be = mem_bus.be; lat_wdata = mem_bus.wdata;
        end else gcnt++;
      end else if (spur_req) begin
        gnt_line = 1'b1; rv_line = 1'b1; rdata_line = 32'h7777_7777; spur_req = 0;
      end
      mem_bus.gnt = gnt_line; mem_bus.rvalid = rv_line; mem_bus.rdata = rdata_line;
      #1;
      monitor();
      requesters();
      if (rv_seen) begin chk_mreq = 1; exp_mreq = i_req_drv || d_req_drv; end
    end
  end

  task automatic wait_idle(input int unsigned budget, input string name);
    int unsigned n = 0;
    while (!(i_stim_q.size() == 0 && d_stim_q.size() == 0 && !i_req_drv && !d_req_drv &&
             rsp_q.size() == 0 && !phase && !spur_req && mem_bus.req === 1'b0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
      flush_tb();
    end
    check({name, " grants all seen"}, ord_q.size(), 0);
    @(posedge clk);
    #2;
  endtask

  vec_t vecs [8];

  initial begin
    mem_arr[32'h100]  = 32'h0000_0013;
    mem_arr[32'h104]  = 32'h0050_0093;
    mem_arr[32'h2000] = 32'h1122_3344;
    mem_arr[32'h3000] = 32'hCAFE_F00D;
    //            is_d we  be     addr          wdata         gd rd ewe ebe    exp_rdata     chk
    vecs[0] = '{1'b0, 0, 4'h0, 32'h100,  32'h0,         0, 0, 0, 4'hF, 32'h0000_0013, 1};
    vecs[1] = '{1'b1, 1, 4'h3, 32'h2000, 32'h0000_BEEF, 3, 0, 1, 4'h3, 32'h0,         0};
    vecs[2] = '{1'b1, 0, 4'hF, 32'h2000, 32'h0,         0, 1, 0, 4'hF, 32'h1122_BEEF, 1};
    vecs[3] = '{1'b0, 0, 4'h0, 32'h104,  32'h0,         1, 2, 0, 4'hF, 32'h0050_0093, 1};
    vecs[4] = '{1'b1, 1, 4'hC, 32'h3000, 32'h1234_0000, 0, 0, 1, 4'hC, 32'h0,         0};
    vecs[5] = '{1'b1, 0, 4'hF, 32'h3000, 32'h0,         2, 0, 0, 4'hF, 32'h1234_F00D, 1};
    vecs[6] = '{1'b1, 0, 4'hF, 32'h4004, 32'h0,         0, 0, 0, 4'hF, 32'hFFFF_BFFB, 1};
    vecs[7] = '{1'b0, 0, 4'h0, 32'h2000, 32'h0,         0, 3, 0, 4'hF, 32'h1122_BEEF, 1};

    repeat (2) @(posedge clk);
    #2;
    check("reset m_req", mem_bus.req, 0);
    check("reset m_we", mem_bus.we, 0);
    check("reset m_be", mem_bus.be, 0);
    check("reset m_addr", mem_bus.addr, 0);
    check("reset m_wdata", mem_bus.wdata, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    foreach (vecs[k]) begin
      gnt_dly = vecs[k].gd; rsp_dly = vecs[k].rd;
      ord_q.push_back(vecs[k].is_d ? DATA : INSTR);
      push_txn(vecs[k].is_d, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wdata,
               vecs[k].exp_we, vecs[k].exp_be, vecs[k].exp_rdata, vecs[k].chk_rdata);
      wait_idle(100, $sformatf("vector %0d", k));
    end

    // Simultaneous requests: data first, fetch back-to-back.
    gnt_dly = 0; rsp_dly = 0;
    ord_q.push_back(DATA); ord_q.push_back(INSTR);
    push_txn(1, 0, 4'hF, 32'h3000, 32'h0, 0, 4'hF, 32'h1234_F00D, 1);
    push_txn(0, 0, 4'h0, 32'h100, 32'h0, 0, 4'hF, 32'h0000_0013, 1);
    wait_idle(100, "simultaneous");

    // Sustained contention.
    for (int k = 0; k < 9; k++)
      push_txn(1, 0, 4'hF, 32'h5000 + 32'(k * 4), 32'h0, 0, 4'hF, ~(32'h5000 + 32'(k * 4)), 1);
    push_txn(0, 0, 4'h0, 32'h100, 32'h0, 0, 4'hF, 32'h0000_0013, 1);
    push_txn(0, 0, 4'h0, 32'h104, 32'h0, 0, 4'hF, 32'h0050_0093, 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 2; k++) begin
      repeat (4) ord_q.push_back(DATA);
      ord_q.push_back(INSTR);
    end
    ord_q.push_back(DATA);
`else
    repeat (9) ord_q.push_back(DATA);
    repeat (2) ord_q.push_back(INSTR);
`endif
    wait_idle(300, "contention");

    // Reset while the data response is outstanding; memory answers after release.
    gnt_dly = 0; rsp_dly = 3; d_gnt_seen = 0;
    ord_q.push_back(DATA);
    push_txn(1, 0, 4'hF, 32'h3000, 32'h0, 0, 4'hF, 32'h1234_F00D, 1);
    for (int n = 0; n < 50 && !d_gnt_seen; n++) @(posedge clk);
    check("reset test reached gnt", d_gnt_seen, 1);
    #2;
    reset_n = 1'b0;
    flush_tb();
    #1;
    check("async reset m_req", mem_bus.req, 0);
    check("async reset m_addr", mem_bus.addr, 0);
    check("async reset m_we", mem_bus.we, 0);
    check("async reset m_be", mem_bus.be, 0);
    check("async reset m_wdata", mem_bus.wdata, 0);
    check("async reset d_gnt", data_bus.gnt, 0);
    check("async reset d_rvalid", data_bus.rvalid, 0);
    check("d_rdata follows m_rdata in reset", data_bus.rdata, mem_bus.rdata);
    check("i_rdata follows m_rdata in reset", instr_bus.rdata, mem_bus.rdata);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    wait_idle(100, "post-reset drain");
    rsp_dly = 0;
    ord_q.push_back(INSTR);
    push_txn(0, 0, 4'h0, 32'h104, 32'h0, 0, 4'hF, 32'h0050_0093, 1);
    wait_idle(100, "after reset");

    // Stray m_gnt/m_rvalid while idle, then a normal request.
    spur_req = 1;
    wait_idle(20, "spurious");
    ord_q.push_back(DATA);
    push_txn(1, 0, 4'hF, 32'h2000, 32'h0, 0, 4'hF, 32'h1122_BEEF, 1);
    wait_idle(100, "after spurious");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
